// File: rtl/rv_execute_stage.sv
// ============================================================================
// rv_execute_stage
// ----------------------------------------------------------------------------
// Execute (EX) stage of a 3-stage RV32I pipeline (IF/ID -> EX -> WB).
//
// The stage takes the decoded operands and controls from IF/ID and does four
// things. It computes the ALU result. It computes the load/store effective
// address. It resolves the branch/jump target and decides whether fetch is
// redirected. It then registers the selected result and the write-back
// controls into the EX->WB pipeline register.
//
// A taken branch or jump is fed back from wb_branch / wb_branch_nxt through
// wb_branch_i / wb_branch_nxt_i. Those two flags kill the two instructions
// that were fetched down the wrong path. Killed slots produce no architectural
// side effects: no rd write, no store, no load, no redirect.
//
// Optional build macro:
//   EXE_X0_SUPPRESS_EN - when defined, rd writes (ALU and load) aimed at x0
//                        are dropped here instead of in the register file.
//
// Ports:
//   clk               pipeline clock, rising edge
//   reset             asynchronous, active-low reset
//   reg_rdata1/2      rs1 / rs2 values
//   execute_imm       sign-extended immediate (U-type already shifted)
//   pc                PC of the instruction in EX
//   fetch_pc          current fetch PC
//   immediate_sel     operand2 selects the immediate
//   mem_write         store instruction
//   jal / jalr / lui  jump / link-register jump / load-upper-immediate
//   alu               OP / OP-IMM instruction
//   branch            conditional branch
//   arithsubtype      funct7[5] (SUB / SRA select)
//   mem_to_reg        load instruction
//   stall_read        hold the EX->WB register
//   dest_reg_sel      rd index
//   alu_op            funct3
//   dmem_raddr        load byte offset
//   wb_branch_i       feedback of wb_branch
//   wb_branch_nxt_i   feedback of wb_branch_nxt
//   alu_operand1/2    ALU operands (combinational)
//   write_address     data memory address (combinational)
//   branch_stall      current EX slot is being flushed (combinational)
//   next_pc           next fetch PC (combinational)
//   branch_taken      redirect fetch (combinational)
//   wb_*              registered results / controls for WB
//   mem_alu_operation registered funct3 (load/store size)
// ============================================================================
module rv_execute_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] reg_rdata1,
    input  logic [31:0] reg_rdata2,
    input  logic [31:0] execute_imm,
    input  logic [31:0] pc,
    input  logic [31:0] fetch_pc,
    input  logic        immediate_sel,
    input  logic        mem_write,
    input  logic        jal,
    input  logic        jalr,
    input  logic        lui,
    input  logic        alu,
    input  logic        branch,
    input  logic        arithsubtype,
    input  logic        mem_to_reg,
    input  logic        stall_read,
    input  logic [4:0]  dest_reg_sel,
    input  logic [2:0]  alu_op,
    input  logic [1:0]  dmem_raddr,
    input  logic        wb_branch_i,
    input  logic        wb_branch_nxt_i,
    output logic [31:0] alu_operand1,
    output logic [31:0] alu_operand2,
    output logic [31:0] write_address,
    output logic        branch_stall,
    output logic [31:0] next_pc,
    output logic        branch_taken,
    output logic [31:0] wb_result,
    output logic        wb_mem_write,
    output logic        wb_alu_to_reg,
    output logic [4:0]  wb_dest_reg_sel,
    output logic        wb_branch,
    output logic        wb_branch_nxt,
    output logic        wb_mem_to_reg,
    output logic [1:0]  wb_read_address,
    output logic [2:0]  mem_alu_operation
);

    localparam int DATA_W = 32;

    // ------------------------------------------------------------------
    // Integer ALU. Operands arrive signed. Signed ops (SLT, SRA) use them
    // directly, and unsigned ops cast back explicitly.
    // ------------------------------------------------------------------
    function automatic logic signed [DATA_W-1:0] alu_calc(
        input logic [2:0]               op,
        input logic                     do_sub,
        input logic                     do_sra,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic [4:0] shamt;
        shamt = b[4:0];
        case (op)
            3'b000:  alu_calc = do_sub ? (a - b) : (a + b);
            3'b001:  alu_calc = a << shamt;
            3'b010:  alu_calc = {{(DATA_W-1){1'b0}}, (a < b)};
            3'b011:  alu_calc = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
            3'b100:  alu_calc = a ^ b;
            3'b101:  alu_calc = do_sra ? (a >>> shamt) : $signed($unsigned(a) >> shamt);
            3'b110:  alu_calc = a | b;
            default: alu_calc = a & b;
        endcase
    endfunction

    // Branch condition on rs1 vs rs2. funct3 010/011 are not branches.
    function automatic logic branch_cond(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        case (op)
            3'b000:  branch_cond = (a == b);
            3'b001:  branch_cond = (a != b);
            3'b100:  branch_cond = (a < b);
            3'b101:  branch_cond = (a >= b);
            3'b110:  branch_cond = ($unsigned(a) < $unsigned(b));
            3'b111:  branch_cond = ($unsigned(a) >= $unsigned(b));
            default: branch_cond = 1'b0;
        endcase
    endfunction

    // ---- stage p0: combinational execute ---------------------------------
    logic signed [DATA_W-1:0] op1_p0;
    logic signed [DATA_W-1:0] op2_p0;
    logic signed [DATA_W-1:0] rs2_p0;
    logic signed [DATA_W-1:0] alu_res_p0;
    logic [DATA_W-1:0]        addr_sum_p0;
    logic [DATA_W-1:0]        link_p0;
    logic [DATA_W-1:0]        rel_target_p0;
    logic [DATA_W-1:0]        result_p0;
    logic                     kill_p0;
    logic                     cond_p0;
    logic                     taken_raw_p0;
    logic                     taken_p0;
    logic                     sub_p0;
    logic                     rd_wr_p0;
    logic                     ld_p0;
    logic                     x0_ok_p0;

    assign op1_p0 = $signed(reg_rdata1);
    assign rs2_p0 = $signed(reg_rdata2);
    assign op2_p0 = immediate_sel ? $signed(execute_imm) : rs2_p0;

    // The kill window covers the two slots that follow a taken redirect.
    assign kill_p0 = wb_branch_i | wb_branch_nxt_i;

    // SUB exists only in register-register form. ADDI with funct7-looking
    // immediate bits must still add. SRAI legitimately uses the bit.
    assign sub_p0     = arithsubtype & ~immediate_sel;
    assign alu_res_p0 = alu_calc(alu_op, sub_p0, arithsubtype, op1_p0, op2_p0);

    // Effective address serves loads, stores and the JALR target.
    assign addr_sum_p0   = reg_rdata1 + execute_imm;
    assign link_p0       = pc + 32'd4;
    assign rel_target_p0 = pc + execute_imm;

    assign cond_p0      = branch_cond(alu_op, op1_p0, rs2_p0);
    assign taken_raw_p0 = jal | jalr | (branch & cond_p0);
    // A held pipeline must not redirect, or the redirect would repeat.
    assign taken_p0     = taken_raw_p0 & ~kill_p0 & ~stall_read;

    always_comb begin
        if (jalr) begin
            next_pc = {addr_sum_p0[DATA_W-1:1], 1'b0};
        end else if (jal | (branch & cond_p0)) begin
            next_pc = rel_target_p0;
        end else begin
            next_pc = fetch_pc + 32'd4;
        end
    end

    always_comb begin
        if (lui) begin
            result_p0 = execute_imm;
        end else if (jal | jalr) begin
            result_p0 = link_p0;
        end else if (alu) begin
            result_p0 = $unsigned(alu_res_p0);
        end else begin
            result_p0 = addr_sum_p0;
        end
    end

`ifdef EXE_X0_SUPPRESS_EN
    assign x0_ok_p0 = (dest_reg_sel != 5'd0);
`else
    assign x0_ok_p0 = 1'b1;
`endif

    assign rd_wr_p0 = (alu | lui | jal | jalr) & ~kill_p0 & x0_ok_p0;
    assign ld_p0    = mem_to_reg & ~kill_p0 & x0_ok_p0;

    assign alu_operand1  = $unsigned(op1_p0);
    assign alu_operand2  = $unsigned(op2_p0);
    assign write_address = addr_sum_p0;
    assign branch_stall  = kill_p0;
    assign branch_taken  = taken_p0;

    // ---- stage p1: EX->WB pipeline register ------------------------------
    logic [DATA_W-1:0] result_p1;
    logic              mem_write_p1;
    logic              rd_wr_p1;
    logic [4:0]        dest_p1;
    logic              branch_p1;
    logic              branch_nxt_p1;
    logic              ld_p1;
    logic [1:0]        raddr_p1;
    logic [2:0]        size_p1;

    // Reset clears the whole register. The WB stage must see no valid
    // write, store or redirect coming out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_p1     <= '0;
            mem_write_p1  <= 1'b0;
            rd_wr_p1      <= 1'b0;
            dest_p1       <= '0;
            branch_p1     <= 1'b0;
            branch_nxt_p1 <= 1'b0;
            ld_p1         <= 1'b0;
            raddr_p1      <= '0;
            size_p1       <= '0;
        end else if (!stall_read) begin
            result_p1     <= result_p0;
            mem_write_p1  <= mem_write & ~kill_p0;
            rd_wr_p1      <= rd_wr_p0;
            dest_p1       <= dest_reg_sel;
            branch_p1     <= taken_p0;
            branch_nxt_p1 <= branch_p1;
            ld_p1         <= ld_p0;
            raddr_p1      <= dmem_raddr;
            size_p1       <= alu_op;
        end
    end

    assign wb_result         = result_p1;
    assign wb_mem_write      = mem_write_p1;
    assign wb_alu_to_reg     = rd_wr_p1;
    assign wb_dest_reg_sel   = dest_p1;
    assign wb_branch         = branch_p1;
    assign wb_branch_nxt     = branch_nxt_p1;
    assign wb_mem_to_reg     = ld_p1;
    assign wb_read_address   = raddr_p1;
    assign mem_alu_operation = size_p1;

endmodule

// File: tb/tb_rv_execute_stage.sv
module tb_rv_execute_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] reg_rdata1, reg_rdata2, execute_imm, pc, fetch_pc;
    logic        immediate_sel, mem_write, jal, jalr, lui, alu, branch;
    logic        arithsubtype, mem_to_reg, stall_read;
    logic [4:0]  dest_reg_sel;
    logic [2:0]  alu_op;
    logic [1:0]  dmem_raddr;
    logic        wb_branch_i, wb_branch_nxt_i;
    logic [31:0] alu_operand1, alu_operand2, write_address, next_pc, wb_result;
    logic        branch_stall, branch_taken, wb_mem_write, wb_alu_to_reg;
    logic [4:0]  wb_dest_reg_sel;
    logic        wb_branch, wb_branch_nxt, wb_mem_to_reg;
    logic [1:0]  wb_read_address;
    logic [2:0]  mem_alu_operation;

    // Feedback path: either the real loop-back or bench-driven values.
    logic tie_fb = 1'b0;
    logic drv_bi = 1'b0;
    logic drv_bni = 1'b0;
    assign wb_branch_i     = tie_fb ? wb_branch     : drv_bi;
    assign wb_branch_nxt_i = tie_fb ? wb_branch_nxt : drv_bni;

    int checks = 0;
    int failures = 0;

    // Reference model state (EX->WB register contents)
    logic [31:0] m_result = 0;
    logic        m_mem_write = 0, m_alu_to_reg = 0, m_branch = 0, m_branch_nxt = 0, m_mem_to_reg = 0;
    logic [4:0]  m_dest = 0;
    logic [1:0]  m_raddr = 0;
    logic [2:0]  m_op = 0;
    // Expected combinational values
    logic [31:0] e_op2, e_waddr, e_npc, e_res;
    logic        e_kill, e_taken, e_rdwr, e_ld;

    always #5 clk = ~clk;

    rv_execute_stage dut (
        .clk(clk), .reset(reset),
        .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .execute_imm(execute_imm),
        .pc(pc), .fetch_pc(fetch_pc), .immediate_sel(immediate_sel), .mem_write(mem_write),
        .jal(jal), .jalr(jalr), .lui(lui), .alu(alu), .branch(branch),
        .arithsubtype(arithsubtype), .mem_to_reg(mem_to_reg), .stall_read(stall_read),
        .dest_reg_sel(dest_reg_sel), .alu_op(alu_op), .dmem_raddr(dmem_raddr),
        .wb_branch_i(wb_branch_i), .wb_branch_nxt_i(wb_branch_nxt_i),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .write_address(write_address),
        .branch_stall(branch_stall), .next_pc(next_pc), .branch_taken(branch_taken),
        .wb_result(wb_result), .wb_mem_write(wb_mem_write), .wb_alu_to_reg(wb_alu_to_reg),
        .wb_dest_reg_sel(wb_dest_reg_sel), .wb_branch(wb_branch), .wb_branch_nxt(wb_branch_nxt),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_read_address(wb_read_address),
        .mem_alu_operation(mem_alu_operation)
    );

    // ---------------- behavioural reference ----------------
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic as, input logic imsel,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'd0: return (as && !imsel) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return (as && a[31]) ? ~((~a) >> sh) : (a >> sh);
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_cond(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (op)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return slt;
            3'd5: return !slt;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compute_expected();
        logic c, x0ok;
        e_kill  = tie_fb ? (m_branch | m_branch_nxt) : (drv_bi | drv_bni);
        e_op2   = immediate_sel ? execute_imm : reg_rdata2;
        e_waddr = reg_rdata1 + execute_imm;
        c       = branch && ref_cond(alu_op, reg_rdata1, reg_rdata2);
        e_taken = (jal || jalr || c) && !e_kill && !stall_read;
        if (jalr)          e_npc = (reg_rdata1 + execute_imm) & 32'hFFFF_FFFE;
        else if (jal || c) e_npc = pc + execute_imm;
        else               e_npc = fetch_pc + 4;
        if (lui)               e_res = execute_imm;
        else if (jal || jalr)  e_res = pc + 4;
        else if (alu)          e_res = ref_alu(alu_op, arithsubtype, immediate_sel, reg_rdata1, e_op2);
        else                   e_res = e_waddr;
`ifdef EXE_X0_SUPPRESS_EN
        x0ok = (dest_reg_sel != 0);
`else
        x0ok = 1'b1;
`endif
        e_rdwr = (alu || lui || jal || jalr) && !e_kill && x0ok;
        e_ld   = mem_to_reg && !e_kill && x0ok;
    endtask

    task automatic model_zero();
        m_result = 0; m_mem_write = 0; m_alu_to_reg = 0; m_dest = 0; m_branch = 0;
        m_branch_nxt = 0; m_mem_to_reg = 0; m_raddr = 0; m_op = 0;
    endtask

    // Advance one clock and the model with it; returns 1 ns after the edge.
    task automatic tick();
        compute_expected();
        @(posedge clk);
        #1;
        if (!reset) model_zero();
        else if (!stall_read) begin
            m_branch_nxt = m_branch;
            m_branch     = e_taken;
            m_result     = e_res;
            m_mem_write  = mem_write && !e_kill;
            m_alu_to_reg = e_rdwr;
            m_dest       = dest_reg_sel;
            m_mem_to_reg = e_ld;
            m_raddr      = dmem_raddr;
            m_op         = alu_op;
        end
    endtask

    task automatic clear_inputs();
        reg_rdata1 = 0; reg_rdata2 = 0; execute_imm = 0; pc = 0; fetch_pc = 0;
        immediate_sel = 0; mem_write = 0; jal = 0; jalr = 0; lui = 0; alu = 0; branch = 0;
        arithsubtype = 0; mem_to_reg = 0; stall_read = 0; dest_reg_sel = 0; alu_op = 0;
        dmem_raddr = 0; drv_bi = 0; drv_bni = 0; tie_fb = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reg_rdata1 = 32'hDEAD_BEEF; alu = 1; dest_reg_sel = 5'd9; jal = 1; pc = 32'h40; dmem_raddr = 2'd3; alu_op = 3'd5;
        tick();
        checks++; if (wb_result !== 0) begin failures++; $display("FAIL rst_result got=%h exp=0", wb_result); end
        checks++; if ({wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg} !== 5'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=00000", {wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg}); end
        checks++; if ({wb_dest_reg_sel, wb_read_address, mem_alu_operation} !== 10'b0) begin
            failures++; $display("FAIL rst_fields got=%h exp=0", {wb_dest_reg_sel, wb_read_address, mem_alu_operation}); end
        checks++; if (alu_operand1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rst_comb_op1 got=%h exp=deadbeef", alu_operand1); end
        @(negedge clk); reset = 1'b1;
        clear_inputs();
    endtask

    task automatic test_add_sub();
        clear_inputs();
        reg_rdata1 = 32'h10; reg_rdata2 = 32'h4; alu = 1; alu_op = 0; dest_reg_sel = 5;
        tick();
        checks++; if (wb_result !== 32'h14) begin failures++; $display("FAIL add_result got=%h exp=14", wb_result); end
        checks++; if (wb_alu_to_reg !== 1'b1) begin failures++; $display("FAIL add_rdwr got=%b exp=1", wb_alu_to_reg); end
        checks++; if (wb_dest_reg_sel !== 5'd5) begin failures++; $display("FAIL add_dest got=%0d exp=5", wb_dest_reg_sel); end
        arithsubtype = 1;
        tick();
        checks++; if (wb_result !== 32'h0C) begin failures++; $display("FAIL sub_result got=%h exp=0c", wb_result); end
        immediate_sel = 1; execute_imm = 32'hFFFF_FFFF;
        #1;
        checks++; if (alu_operand2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL addi_op2 got=%h exp=ffffffff", alu_operand2); end
        tick();
        checks++; if (wb_result !== 32'h0F) begin failures++; $display("FAIL addi_nosub got=%h exp=0f", wb_result); end
    endtask

    task automatic test_bne_kill();
        clear_inputs();
        tie_fb = 1;
        branch = 1; alu_op = 3'd1; reg_rdata1 = 32'h10; reg_rdata2 = 32'h4; pc = 32'h100; execute_imm = 32'h20;
        #1;
        checks++; if (branch_taken !== 1'b1) begin failures++; $display("FAIL bne_taken got=%b exp=1", branch_taken); end
        checks++; if (next_pc !== 32'h120) begin failures++; $display("FAIL bne_npc got=%h exp=120", next_pc); end
        tick();
        checks++; if (wb_branch !== 1'b1) begin failures++; $display("FAIL bne_wb_branch got=%b exp=1", wb_branch); end
        // First killed slot: a JAL that must not redirect or write rd
        branch = 0; jal = 1; dest_reg_sel = 5'd7; pc = 32'h104; execute_imm = 32'h40;
        #1;
        checks++; if (branch_stall !== 1'b1) begin failures++; $display("FAIL kill1_stall got=%b exp=1", branch_stall); end
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL kill1_taken got=%b exp=0", branch_taken); end
        tick();
        checks++; if (wb_alu_to_reg !== 1'b0) begin failures++; $display("FAIL kill1_rdwr got=%b exp=0", wb_alu_to_reg); end
        checks++; if (wb_branch_nxt !== 1'b1) begin failures++; $display("FAIL bne_wb_branch_nxt got=%b exp=1", wb_branch_nxt); end
        // Second killed slot: ALU
        jal = 0; alu = 1; alu_op = 3'd0; pc = 32'h108;
        #1;
        checks++; if (branch_stall !== 1'b1) begin failures++; $display("FAIL kill2_stall got=%b exp=1", branch_stall); end
        tick();
        checks++; if (wb_alu_to_reg !== 1'b0) begin failures++; $display("FAIL kill2_rdwr got=%b exp=0", wb_alu_to_reg); end
        // Third slot executes normally
        #1;
        checks++; if (branch_stall !== 1'b0) begin failures++; $display("FAIL slot3_stall got=%b exp=0", branch_stall); end
        tick();
        checks++; if (wb_alu_to_reg !== 1'b1) begin failures++; $display("FAIL slot3_rdwr got=%b exp=1", wb_alu_to_reg); end
        tie_fb = 0;
    endtask

    task automatic test_jalr();
        clear_inputs();
        jalr = 1; reg_rdata1 = 32'h10; execute_imm = 32'h3; pc = 32'h200; dest_reg_sel = 5'd1;
        #1;
        checks++; if (next_pc !== 32'h12) begin failures++; $display("FAIL jalr_npc got=%h exp=12", next_pc); end
        tick();
        checks++; if (wb_result !== 32'h204) begin failures++; $display("FAIL jalr_link got=%h exp=204", wb_result); end
    endtask

    task automatic test_lui_store_load();
        clear_inputs();
        lui = 1; execute_imm = 32'h1234_5000; dest_reg_sel = 5'd3;
        tick();
        checks++; if (wb_result !== 32'h1234_5000) begin failures++; $display("FAIL lui_result got=%h exp=12345000", wb_result); end
        clear_inputs();
        mem_write = 1; reg_rdata1 = 32'h10; execute_imm = 32'h8;
        #1;
        checks++; if (write_address !== 32'h18) begin failures++; $display("FAIL st_addr got=%h exp=18", write_address); end
        tick();
        checks++; if (wb_mem_write !== 1'b1) begin failures++; $display("FAIL st_wb got=%b exp=1", wb_mem_write); end
        checks++; if (wb_alu_to_reg !== 1'b0) begin failures++; $display("FAIL st_rdwr got=%b exp=0", wb_alu_to_reg); end
        clear_inputs();
        mem_to_reg = 1; alu_op = 3'b010; dmem_raddr = 2'd2; reg_rdata1 = 32'h20; execute_imm = 32'h4; dest_reg_sel = 5'd8;
        tick();
        checks++; if (mem_alu_operation !== 3'b010) begin failures++; $display("FAIL ld_size got=%b exp=010", mem_alu_operation); end
        checks++; if (wb_read_address !== 2'd2) begin failures++; $display("FAIL ld_raddr got=%0d exp=2", wb_read_address); end
        checks++; if (wb_mem_to_reg !== 1'b1) begin failures++; $display("FAIL ld_wb got=%b exp=1", wb_mem_to_reg); end
        checks++; if (wb_result !== 32'h24) begin failures++; $display("FAIL ld_addr got=%h exp=24", wb_result); end
    endtask

    task automatic test_stall();
        clear_inputs();
        alu = 1; alu_op = 3'd4; reg_rdata1 = 32'hF0F0; reg_rdata2 = 32'h0FF0; dest_reg_sel = 5'd9;
        tick();
        checks++; if (wb_result !== 32'hFF00) begin failures++; $display("FAIL xor_result got=%h exp=ff00", wb_result); end
        // Hold with new inputs and a simultaneous kill: hold wins
        stall_read = 1; alu = 0; jal = 1; pc = 32'h500; execute_imm = 32'h10; dest_reg_sel = 5'd2; drv_bi = 1;
        #1;
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL stall_taken got=%b exp=0", branch_taken); end
        tick();
        checks++; if (wb_result !== 32'hFF00) begin failures++; $display("FAIL stall_result got=%h exp=ff00", wb_result); end
        checks++; if (wb_dest_reg_sel !== 5'd9) begin failures++; $display("FAIL stall_dest got=%0d exp=9", wb_dest_reg_sel); end
        checks++; if (wb_alu_to_reg !== 1'b1) begin failures++; $display("FAIL stall_rdwr got=%b exp=1", wb_alu_to_reg); end
        checks++; if (wb_branch !== 1'b0) begin failures++; $display("FAIL stall_branch got=%b exp=0", wb_branch); end
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        jal = 1; pc = 32'h80; execute_imm = 32'h10; dest_reg_sel = 5'd4; dmem_raddr = 2'd3; alu_op = 3'd3;
        tick();
        tick();
        checks++; if ({wb_branch, wb_branch_nxt} !== 2'b11) begin failures++; $display("FAIL pre_rst_branch got=%b exp=11", {wb_branch, wb_branch_nxt}); end
        #2;
        reset = 1'b0;
        #1;
        model_zero();
        checks++; if (wb_result !== 0 || wb_dest_reg_sel !== 0 || wb_read_address !== 0 || mem_alu_operation !== 0) begin
            failures++; $display("FAIL async_rst_fields got=%h/%0d/%0d/%0d exp=0", wb_result, wb_dest_reg_sel, wb_read_address, mem_alu_operation); end
        checks++; if ({wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg} !== 5'b0) begin
            failures++; $display("FAIL async_rst_flags got=%b exp=00000", {wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg}); end
        checks++; if (next_pc !== 32'h90) begin failures++; $display("FAIL rst_comb_npc got=%h exp=90", next_pc); end
        clear_inputs();
        alu = 1; reg_rdata1 = 32'h1; reg_rdata2 = 32'h2; dest_reg_sel = 5'd6;
        #1;
        reset = 1'b1;
        tick();
        checks++; if (wb_result !== 32'h3 || wb_dest_reg_sel !== 5'd6) begin
            failures++; $display("FAIL post_rst_capture got=%h/%0d exp=3/6", wb_result, wb_dest_reg_sel); end
    endtask

    task automatic test_not_taken();
        clear_inputs();
        branch = 1; alu_op = 3'd0; reg_rdata1 = 32'h10; reg_rdata2 = 32'h4; fetch_pc = 32'h300; pc = 32'h100; execute_imm = 32'h20;
        #1;
        checks++; if (branch_taken !== 1'b0) begin failures++; $display("FAIL beq_nt_taken got=%b exp=0", branch_taken); end
        checks++; if (next_pc !== 32'h304) begin failures++; $display("FAIL beq_nt_npc got=%h exp=304", next_pc); end
        tick();
        checks++; if (wb_branch !== 1'b0) begin failures++; $display("FAIL beq_nt_wb got=%b exp=0", wb_branch); end
    endtask

    task automatic test_random();
        int kind;
        for (int i = 0; i < 400; i++) begin
            clear_inputs();
            kind = $urandom_range(0, 6);
            reg_rdata1 = $urandom;
            case ($urandom_range(0, 4))
                0: reg_rdata2 = reg_rdata1;
                1: reg_rdata2 = 32'h8000_0000;
                2: reg_rdata2 = 32'h7FFF_FFFF;
                default: reg_rdata2 = $urandom;
            endcase
            execute_imm = $urandom; pc = $urandom & 32'hFFFF_FFFC; fetch_pc = $urandom & 32'hFFFF_FFFC;
            alu_op = 3'($urandom_range(0, 7)); dest_reg_sel = 5'($urandom_range(0, 31));
            dmem_raddr = 2'($urandom_range(0, 3));
            case (kind)
                0: begin alu = 1; immediate_sel = 1'($urandom_range(0, 1)); arithsubtype = 1'($urandom_range(0, 1)); end
                1: lui = 1;
                2: jal = 1;
                3: jalr = 1;
                4: branch = 1;
                5: mem_to_reg = 1;
                default: mem_write = 1;
            endcase
            stall_read = ($urandom_range(0, 9) == 0);
            tie_fb = ($urandom_range(0, 3) != 0);
            drv_bi = ($urandom_range(0, 5) == 0); drv_bni = ($urandom_range(0, 5) == 0);
            #1;
            compute_expected();
            checks++; if (alu_operand1 !== reg_rdata1 || alu_operand2 !== e_op2) begin
                failures++; $display("FAIL rnd_ops i=%0d got=%h/%h exp=%h/%h", i, alu_operand1, alu_operand2, reg_rdata1, e_op2); end
            checks++; if (write_address !== e_waddr) begin failures++; $display("FAIL rnd_waddr i=%0d got=%h exp=%h", i, write_address, e_waddr); end
            checks++; if (next_pc !== e_npc) begin failures++; $display("FAIL rnd_npc i=%0d op=%0d got=%h exp=%h", i, alu_op, next_pc, e_npc); end
            checks++; if (branch_taken !== e_taken || branch_stall !== e_kill) begin
                failures++; $display("FAIL rnd_taken i=%0d got=%b/%b exp=%b/%b", i, branch_taken, branch_stall, e_taken, e_kill); end
            tick();
            checks++; if (wb_result !== m_result) begin failures++; $display("FAIL rnd_result i=%0d op=%0d got=%h exp=%h", i, alu_op, wb_result, m_result); end
            checks++; if ({wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg} !==
                          {m_mem_write, m_alu_to_reg, m_branch, m_branch_nxt, m_mem_to_reg}) begin
                failures++; $display("FAIL rnd_flags i=%0d got=%b exp=%b", i,
                    {wb_mem_write, wb_alu_to_reg, wb_branch, wb_branch_nxt, wb_mem_to_reg},
                    {m_mem_write, m_alu_to_reg, m_branch, m_branch_nxt, m_mem_to_reg}); end
            checks++; if ({wb_dest_reg_sel, wb_read_address, mem_alu_operation} !== {m_dest, m_raddr, m_op}) begin
                failures++; $display("FAIL rnd_fields i=%0d got=%h exp=%h", i,
                    {wb_dest_reg_sel, wb_read_address, mem_alu_operation}, {m_dest, m_raddr, m_op}); end
        end
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_sub();
        test_bne_kill();
        test_jalr();
        test_lui_store_load();
        test_stall();
        test_reset_mid();
        test_not_taken();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_execute_stage.md
Name: rv_execute_stage

Overview:
- Execute (EX) stage of the 3-stage RV32I pipeline (IF/ID → EX → WB).
- Takes decoded operands and controls from IF/ID, then:
  - computes ALU results, load/store addresses and branch/jump targets;
  - resolves control flow combinationally;
  - registers results and controls into the EX→WB pipeline register.

Parameters:
- none (XLEN fixed at 32)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- reg_rdata1  in  32  rs1 value
- reg_rdata2  in  32  rs2 value
- execute_imm  in  32  sign-extended immediate (U-type already shifted)
- pc  in  32  PC of instruction in EX
- fetch_pc  in  32  current fetch PC
- immediate_sel  in  1  operand2 = immediate
- mem_write  in  1  store instruction
- jal  in  1  JAL
- jalr  in  1  JALR
- lui  in  1  LUI
- alu  in  1  ALU (OP/OP-IMM) instruction
- branch  in  1  conditional branch
- arithsubtype  in  1  funct7[5]
- mem_to_reg  in  1  load instruction
- stall_read  in  1  hold pipeline register
- dest_reg_sel  in  5  rd index
- alu_op  in  3  funct3
- dmem_raddr  in  2  load byte offset
- wb_branch_i  in  1  fed back from wb_branch
- wb_branch_nxt_i  in  1  fed back from wb_branch_nxt
- alu_operand1  out  32  ALU operand 1
- alu_operand2  out  32  ALU operand 2
- write_address  out  32  data memory address
- branch_stall  out  1  current EX slot is being flushed
- next_pc  out  32  next fetch PC
- branch_taken  out  1  redirect fetch
- wb_result  out  32  registered result
- wb_mem_write  out  1  registered store
- wb_alu_to_reg  out  1  registered rd write enable (non-load)
- wb_dest_reg_sel  out  5  registered rd
- wb_branch  out  1  registered taken flag
- wb_branch_nxt  out  1  wb_branch delayed one cycle
- wb_mem_to_reg  out  1  registered load
- wb_read_address  out  2  registered dmem_raddr
- mem_alu_operation  out  3  registered alu_op (load/store size)

Behaviour:
- kill = wb_branch_i | wb_branch_nxt_i; branch_stall = kill (combinational).
- alu_operand1 = reg_rdata1.
- alu_operand2 = immediate_sel ? execute_imm : reg_rdata2.
- write_address = reg_rdata1 + execute_imm (wraps mod 2^32).
- ALU by alu_op:
  - 000: ADD, or SUB when arithsubtype=1 and immediate_sel=0
  - 001: SLL
  - 010: SLT (signed)
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA when arithsubtype=1
  - 110: OR
  - 111: AND
  - shift amount = operand2[4:0].
- Branch condition on reg_rdata1 vs reg_rdata2 by alu_op:
  - 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU
  - 010/011: never taken.
- taken_raw = jal | jalr | (branch & cond).
- branch_taken = taken_raw & ~kill & ~stall_read.
- next_pc:
  - jalr: (reg_rdata1 + execute_imm) & ~1
  - jal, or branch with cond true: pc + execute_imm
  - otherwise: fetch_pc + 4
- Result mux: lui → execute_imm; jal|jalr → pc+4; alu → ALU result; otherwise write_address.
- Pipeline register on rising clk:
  - if stall_read=1: all registered outputs hold.
  - else wb_result, wb_dest_reg_sel, wb_read_address and mem_alu_operation load normally.
  - wb_alu_to_reg = (alu|lui|jal|jalr) & ~kill.
  - wb_mem_write = mem_write & ~kill.
  - wb_mem_to_reg = mem_to_reg & ~kill.
  - wb_branch = branch_taken.
  - wb_branch_nxt = wb_branch.
- Latency: 1 cycle from EX inputs to wb_* outputs. A taken branch kills the following two EX slots via feedback.
- Reset (async, reset=0): every registered output = 0. Combinational outputs follow inputs during reset.
- Reset deasserted mid-operation: first edge after release captures the current inputs.
- stall_read together with kill: hold takes priority.

Optional Feature:
- Macro EXE_X0_SUPPRESS_EN.
- Defined: wb_alu_to_reg and wb_mem_to_reg are forced 0 when dest_reg_sel == 0.
- Undefined: rd=x0 writes pass through; the register file discards them.

Test Plan:
- ADD/SUB: rdata1=0x10, rdata2=0x04, alu=1, alu_op=000, dest=5.
  - arithsubtype=0 → next edge wb_result=0x14, wb_alu_to_reg=1, wb_dest_reg_sel=5.
  - arithsubtype=1 → wb_result=0x0C.
  - immediate_sel=1, imm=0xFFFFFFFF, arithsubtype=1 → 0x0F (no SUB).
- BNE: branch=1, alu_op=001, pc=0x100, imm=0x20 → branch_taken=1, next_pc=0x120.
  - wb_branch=1 next cycle, wb_branch_nxt=1 the cycle after.
  - with wb_branch_i tied back, branch_stall=1 and wb_alu_to_reg=0 for the two following slots.
- JALR: rdata1=0x10, imm=0x3, pc=0x200 → next_pc=0x12, wb_result=0x204.
- LUI/store:
  - lui, imm=0x12345000 → wb_result=0x12345000.
  - mem_write, imm=0x8 → write_address=0x18, wb_mem_write=1.
  - load with alu_op=010, dmem_raddr=2 → mem_alu_operation=010, wb_read_address=2.
- Stall and reset:
  - stall_read=1 with new inputs → wb_* unchanged.
  - reset=0 mid-run → all wb_* and mem_alu_operation = 0 immediately, without waiting for a clock edge.
- Not-taken branch: BEQ with 0x10 vs 0x04, fetch_pc=0x300 → branch_taken=0, next_pc=0x304.
